// File: rtl/core_control_mc_if.sv
// Request, memory-controller and processing-unit signals of the core sequencer.
// The master modport is the requester/environment side; the slave modport is the sequencer.
interface core_control_mc_if #(
  parameter int OP_W   = 3,
  parameter int LEN_W  = 6,
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  // Handshake: a request is taken on the rising edge where ctrl_ready,
  // ctrl_valid_inst and ctrl_valid_data are all high.
  logic [OP_W-1:0]   ctrl_instruction;
  logic [CH_W-1:0]   ctrl_channel;
  logic              ctrl_valid_inst;
  logic              ctrl_valid_data;
  logic [LEN_W-1:0]  ctrl_data_in_size;
  logic              ctrl_ready;
  logic              ctrl_done;
  logic              ctrl_error;
  logic [1:0]        ctrl_err_code;
  logic              ctrl_err_clr;
  logic [2:0]        ctrl_data_contition;
  logic [LEN_W-1:0]  ctrl_chunk_cnt;
  logic              mc_done;
  logic              mc_data_done;
  logic [LEN_W-1:0]  mc_data_length;
  logic [OP_W-1:0]   procc_instruction;
  logic [NUM_CH-1:0] procc_start;
  logic [NUM_CH-1:0] procc_done;

  modport slave (
    input  ctrl_instruction, ctrl_channel, ctrl_valid_inst, ctrl_valid_data,
           ctrl_data_in_size, ctrl_err_clr, mc_done, mc_data_done, procc_done,
    output ctrl_ready, ctrl_done, ctrl_error, ctrl_err_code, ctrl_data_contition,
           ctrl_chunk_cnt, mc_data_length, procc_instruction, procc_start
  );

  modport master (
    output ctrl_instruction, ctrl_channel, ctrl_valid_inst, ctrl_valid_data,
           ctrl_data_in_size, ctrl_err_clr, mc_done, mc_data_done, procc_done,
    input  ctrl_ready, ctrl_done, ctrl_error, ctrl_err_code, ctrl_data_contition,
           ctrl_chunk_cnt, mc_data_length, procc_instruction, procc_start
  );
endinterface

// File: rtl/core_control_mc.sv
// Core sequencer: input -> memory -> register, dispatch to one of NUM_CH units,
// iterate chunks until the memory controller runs dry; watchdog and latched error.
module core_control_mc #(
  parameter  int OP_W    = 3,
  parameter  int LEN_W   = 6,
  parameter  int NUM_CH  = 2,
  parameter  int TO_W    = 8,
  parameter  int TIMEOUT = 200,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ctrl_clk,
  input  logic              ctrl_reset,
  core_control_mc_if.slave  bus,
  output logic [2:0]        o_dbg_state
);
  typedef enum logic [2:0] {S_IDLE, S_STORE, S_TRANS, S_PROC, S_ERROR} state_t;

  localparam logic [2:0]      C_NONE  = 3'b000;
  localparam logic [2:0]      C_IN    = 3'b100;
  localparam logic [2:0]      C_MEM   = 3'b010;
  localparam logic [2:0]      C_REG   = 3'b001;
  localparam logic [1:0]      E_NONE  = 2'b00;
  localparam logic [1:0]      E_TO    = 2'b01;
  localparam logic [1:0]      E_CH    = 2'b10;
  localparam bit              WD_EN   = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] WD_MAX  = '1;
  localparam logic [TO_W-1:0] WD_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
  localparam logic [CH_W:0]   CH_LIM  = (CH_W + 1)'(NUM_CH);

  state_t            r_state, w_state;
  logic [TO_W-1:0]   r_wd, w_wd;
  logic [CH_W-1:0]   r_ch, w_ch;
  logic [LEN_W-1:0]  r_len, w_len;
  logic [OP_W-1:0]   r_op, w_op;
  logic [NUM_CH-1:0] r_start, w_start;
  logic [2:0]        r_cond, w_cond;
  logic [LEN_W-1:0]  r_chunk, w_chunk;
  logic [1:0]        r_code, w_code;
  logic              r_ready, w_ready;
  logic              r_done, w_done;
  logic              r_error, w_error;
  logic              w_exit;
  logic              w_accept;
  logic              w_ch_ok;
  logic              w_sel_done;

  assign w_accept   = r_ready & bus.ctrl_valid_inst & bus.ctrl_valid_data;
  assign w_ch_ok    = {1'b0, bus.ctrl_channel} < CH_LIM;
  // r_start is one-hot on the latched channel while in PROC, so it doubles as the done mask.
  assign w_sel_done = |(bus.procc_done & r_start);

  always_comb begin
    w_state = r_state;
    w_ch    = r_ch;
    w_len   = r_len;
    w_op    = r_op;
    w_start = r_start;
    w_cond  = r_cond;
    w_chunk = r_chunk;
    w_code  = r_code;
    w_error = r_error;
    w_done  = 1'b0;
    w_exit  = 1'b0;
    w_wd    = r_wd;
    w_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_ch_ok) begin
            w_state = S_STORE;
            w_len   = bus.ctrl_data_in_size;
            w_op    = bus.ctrl_instruction;
            w_ch    = bus.ctrl_channel;
            w_chunk = '0;
            w_cond  = C_IN;
          end else begin
            w_state = S_ERROR;
            w_error = 1'b1;
            w_code  = E_CH;
          end
        end
      end
      S_STORE: begin
        if (bus.mc_done) begin
          w_exit  = 1'b1;
          w_state = S_TRANS;
          w_cond  = C_MEM;
        end
      end
      S_TRANS: begin
        if (bus.mc_done) begin
          w_exit  = 1'b1;
          w_state = S_PROC;
          w_cond  = C_REG;
          w_start = NUM_CH'(1) << r_ch;
        end
      end
      S_PROC: begin
        if (w_sel_done) begin
          w_exit  = 1'b1;
          w_start = '0;
          w_chunk = r_chunk + LEN_W'(1);
          if (bus.mc_data_done) begin
            w_state = S_IDLE;
            w_cond  = C_NONE;
            w_done  = 1'b1;
          end else begin
            w_state = S_TRANS;
            w_cond  = C_MEM;
          end
        end
      end
      S_ERROR: begin
        if (bus.ctrl_err_clr) begin
          w_state = S_IDLE;
          w_error = 1'b0;
          w_code  = E_NONE;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // r_wd counts completed wait cycles, so the TIMEOUT-th wait cycle without an exit trips.
    if (WD_EN && (r_state inside {S_STORE, S_TRANS, S_PROC}) && !w_exit && (r_wd == WD_LAST)) begin
      w_state = S_ERROR;
      w_error = 1'b1;
      w_code  = E_TO;
      w_cond  = C_NONE;
      w_start = '0;
    end

    if (w_state != r_state)
      w_wd = '0;
    else if (r_state inside {S_STORE, S_TRANS, S_PROC})
      w_wd = (r_wd == WD_MAX) ? r_wd : r_wd + TO_W'(1);

    w_ready = (w_state == S_IDLE);
  end

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_reset) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
      r_ch    <= '0;
      r_len   <= '0;
      r_op    <= '0;
      r_start <= '0;
      r_cond  <= C_NONE;
      r_chunk <= '0;
      r_code  <= E_NONE;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state;
      r_wd    <= w_wd;
      r_ch    <= w_ch;
      r_len   <= w_len;
      r_op    <= w_op;
      r_start <= w_start;
      r_cond  <= w_cond;
      r_chunk <= w_chunk;
      r_code  <= w_code;
      r_ready <= w_ready;
      r_done  <= w_done;
      r_error <= w_error;
    end
  end

  assign bus.ctrl_ready          = r_ready;
  assign bus.ctrl_done           = r_done;
  assign bus.ctrl_error          = r_error;
  assign bus.ctrl_err_code       = r_code;
  assign bus.ctrl_data_contition = r_cond;
  assign bus.ctrl_chunk_cnt      = r_chunk;
  assign bus.mc_data_length      = r_len;
  assign bus.procc_instruction   = r_op;
  assign bus.procc_start         = r_start;
  assign o_dbg_state             = r_state;
endmodule

// File: tb/tb_core_control_mc.sv
// Bench for core_control_mc: directed scenarios plus randomized multi-chunk requests
// checked against a transaction-level model of data-location sequence, counts and flags.
module tb_core_control_mc;
  localparam int OP_W    = 3;
  localparam int LEN_W   = 6;
  localparam int NUM_CH  = 3;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  core_control_mc_if #(.OP_W(OP_W), .LEN_W(LEN_W), .NUM_CH(NUM_CH)) bus ();

  core_control_mc #(
    .OP_W(OP_W), .LEN_W(LEN_W), .NUM_CH(NUM_CH), .TO_W(TO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .ctrl_clk    (clk),
    .ctrl_reset  (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  int         done_cnt = 0;
  logic [2:0] last_cond = 3'b000;
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];

  // Monitor: record every change of the data location and count done cycles.
  always @(negedge clk) begin
    if (bus.ctrl_done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.ctrl_data_contition !== last_cond) begin
      obs_q.push_back(bus.ctrl_data_contition);
      last_cond <= bus.ctrl_data_contition;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got still running want finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ctrl_instruction  = '0;
    bus.ctrl_channel      = '0;
    bus.ctrl_valid_inst   = 1'b0;
    bus.ctrl_valid_data   = 1'b0;
    bus.ctrl_data_in_size = '0;
    bus.ctrl_err_clr      = 1'b0;
    bus.mc_done           = 1'b0;
    bus.mc_data_done      = 1'b0;
    bus.procc_done        = '0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (bus.ctrl_ready !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk("ready_wait", 32'(bus.ctrl_ready), 32'd1);
  endtask

  task automatic accept(input int ch, input int size, input int op);
    wait_ready();
    bus.ctrl_channel      = 2'(ch);
    bus.ctrl_data_in_size = 6'(size);
    bus.ctrl_instruction  = 3'(op);
    bus.ctrl_valid_inst   = 1'b1;
    bus.ctrl_valid_data   = 1'b1;
    step();
    bus.ctrl_valid_inst   = 1'b0;
    bus.ctrl_valid_data   = 1'b0;
  endtask

  task automatic pulse_mc();
    bus.mc_done = 1'b1;
    step();
    bus.mc_done = 1'b0;
  endtask

  // Idle cycles in STORE/TRANS with unrelated unit-done noise that must be ignored.
  task automatic wait_noise(input int n);
    for (int i = 0; i < n; i++) begin
      bus.procc_done   = 3'($urandom_range(0, 7));
      bus.mc_data_done = 1'($urandom_range(0, 1));
      step();
    end
    bus.procc_done   = '0;
    bus.mc_data_done = 1'b0;
  endtask

  task automatic run_txn(input int ch, input int size, input int op, input int n);
    logic [2:0] oh;
    int         d0;
    oh = 3'(1 << ch);
    d0 = done_cnt;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(3'b100);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b001);
    end
    exp_q.push_back(3'b000);

    accept(ch, size, op);
    chk("len_latched", 32'(bus.mc_data_length), 32'(size));
    chk("op_latched", 32'(bus.procc_instruction), 32'(op));
    chk("chunk_start", 32'(bus.ctrl_chunk_cnt), 32'd0);
    wait_noise($urandom_range(0, 3));
    pulse_mc();
    for (int i = 0; i < n; i++) begin
      wait_noise($urandom_range(0, 3));
      pulse_mc();
      chk("start_onehot", 32'(bus.procc_start), 32'(oh));
      for (int k = 0, m = $urandom_range(0, 3); k < m; k++) begin
        bus.procc_done   = 3'($urandom_range(0, 7)) & ~oh;
        bus.mc_done      = 1'($urandom_range(0, 1));
        bus.mc_data_done = 1'($urandom_range(0, 1));
        step();
      end
      bus.mc_done      = 1'b0;
      bus.procc_done   = oh | (3'($urandom_range(0, 7)) & ~oh);
      bus.mc_data_done = (i == n - 1);
      step();
      bus.procc_done   = '0;
      bus.mc_data_done = 1'b0;
      chk("chunk_cnt", 32'(bus.ctrl_chunk_cnt), 32'((i + 1) % 64));
      chk("start_drop", 32'(bus.procc_start), 32'd0);
      if (i == n - 1) chk("done_pulse", 32'(bus.ctrl_done), 32'd1);
      else            chk("no_early_done", 32'(bus.ctrl_done), 32'd0);
    end
    step();
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("done_low", 32'(bus.ctrl_done), 32'd0);
    chk("ready_after", 32'(bus.ctrl_ready), 32'd1);
    chk("error_clear", 32'(bus.ctrl_error), 32'd0);
    chk("cond_len", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk("cond_seq", 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_error();
    bus.ctrl_err_clr = 1'b1;
    step();
    bus.ctrl_err_clr = 1'b0;
  endtask

  initial begin
    int d0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ready", 32'(bus.ctrl_ready), 32'd0);
    chk("rst_done", 32'(bus.ctrl_done), 32'd0);
    chk("rst_error", 32'(bus.ctrl_error), 32'd0);
    chk("rst_code", 32'(bus.ctrl_err_code), 32'd0);
    chk("rst_cond", 32'(bus.ctrl_data_contition), 32'd0);
    chk("rst_chunk", 32'(bus.ctrl_chunk_cnt), 32'd0);
    chk("rst_start", 32'(bus.procc_start), 32'd0);
    chk("rst_len", 32'(bus.mc_data_length), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_out_of_reset", 32'(bus.ctrl_ready), 32'd1);

    // Stray memory/unit completions in IDLE change nothing.
    bus.mc_done = 1'b1; bus.procc_done = 3'b111; bus.mc_data_done = 1'b1;
    step();
    idle_inputs();
    chk("idle_ignore_cond", 32'(bus.ctrl_data_contition), 32'd0);
    chk("idle_ignore_ready", 32'(bus.ctrl_ready), 32'd1);

    run_txn(0, 12, 5, 1);
    run_txn(1, $urandom_range(0, 63), $urandom_range(0, 7), 3);

    // Watchdog in STORE: the fifth wait cycle without mc_done trips.
    accept(2, 9, 3);
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      chk("to_store_wait", 32'(bus.ctrl_error), 32'd0);
    end
    step();
    chk("to_store_err", 32'(bus.ctrl_error), 32'd1);
    chk("to_store_code", 32'(bus.ctrl_err_code), 32'd1);
    chk("to_store_cond", 32'(bus.ctrl_data_contition), 32'd0);
    chk("to_store_ready", 32'(bus.ctrl_ready), 32'd0);
    chk("to_store_nodone", 32'(bus.ctrl_done), 32'd0);
    bus.mc_done = 1'b1; bus.ctrl_valid_inst = 1'b1; bus.ctrl_valid_data = 1'b1;
    step();
    idle_inputs();
    chk("err_sticky", 32'(bus.ctrl_error), 32'd1);
    clear_error();
    chk("clr_error", 32'(bus.ctrl_error), 32'd0);
    chk("clr_code", 32'(bus.ctrl_err_code), 32'd0);
    chk("clr_ready", 32'(bus.ctrl_ready), 32'd1);
    chk("clr_chunk", 32'(bus.ctrl_chunk_cnt), 32'd0);

    // Watchdog in PROC after one finished chunk; the count survives the clear.
    accept(0, 20, 6);
    pulse_mc();
    pulse_mc();
    bus.procc_done = 3'b001;
    step();
    bus.procc_done = '0;
    pulse_mc();
    for (int k = 1; k < TIMEOUT; k++) step();
    chk("to_proc_wait", 32'(bus.ctrl_error), 32'd0);
    step();
    chk("to_proc_err", 32'(bus.ctrl_error), 32'd1);
    chk("to_proc_start", 32'(bus.procc_start), 32'd0);
    clear_error();
    chk("to_proc_chunk_kept", 32'(bus.ctrl_chunk_cnt), 32'd1);

    // Exit on the very cycle the watchdog would fire wins, in every wait state.
    d0 = done_cnt;
    accept(1, 33, 2);
    for (int k = 1; k < TIMEOUT; k++) step();
    pulse_mc();
    chk("race_store_err", 32'(bus.ctrl_error), 32'd0);
    chk("race_store_cond", 32'(bus.ctrl_data_contition), 32'b010);
    for (int k = 1; k < TIMEOUT; k++) step();
    pulse_mc();
    chk("race_trans_cond", 32'(bus.ctrl_data_contition), 32'b001);
    chk("race_trans_start", 32'(bus.procc_start), 32'b010);
    for (int k = 1; k < TIMEOUT; k++) step();
    bus.procc_done = 3'b010; bus.mc_data_done = 1'b1;
    step();
    idle_inputs();
    chk("race_proc_done", 32'(bus.ctrl_done), 32'd1);
    chk("race_proc_err", 32'(bus.ctrl_error), 32'd0);
    step();
    chk("race_done_count", 32'(done_cnt - d0), 32'd1);

    // Channel beyond NUM_CH: straight to ERROR, nothing latched.
    accept(3, 44, 7);
    chk("badch_err", 32'(bus.ctrl_error), 32'd1);
    chk("badch_code", 32'(bus.ctrl_err_code), 32'd2);
    chk("badch_start", 32'(bus.procc_start), 32'd0);
    chk("badch_len_kept", 32'(bus.mc_data_length), 32'd33);
    step();
    chk("badch_no_store", 32'(bus.ctrl_data_contition), 32'd0);
    clear_error();
    chk("badch_clr", 32'(bus.ctrl_ready), 32'd1);

    // Reset while a unit is running.
    d0 = done_cnt;
    accept(2, 5, 1);
    pulse_mc();
    pulse_mc();
    chk("pre_rst_start", 32'(bus.procc_start), 32'b100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_start", 32'(bus.procc_start), 32'd0);
    chk("mid_rst_cond", 32'(bus.ctrl_data_contition), 32'd0);
    chk("mid_rst_len", 32'(bus.mc_data_length), 32'd0);
    chk("mid_rst_op", 32'(bus.procc_instruction), 32'd0);
    chk("mid_rst_done", 32'(bus.ctrl_done), 32'd0);
    step();
    chk("mid_rst_no_pulse", 32'(done_cnt - d0), 32'd0);
    run_txn(2, 17, 4, 2);

    for (int t = 0; t < 6; t++)
      run_txn($urandom_range(0, 2), $urandom_range(0, 63), $urandom_range(0, 7),
              $urandom_range(1, 4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/core_control_mc.md
Name: core_control_mc

Overview:
- Parametrised successor of the core sequencer. Moves a data block through the memory controller: input → memory, then memory → register. Dispatches the block to one of NUM_CH processing units and iterates chunks until the memory controller reports the data exhausted.
- Adds the following:
  - a ready/accept handshake
  - a done pulse
  - a chunk counter
  - a per-state watchdog timeout
  - a latched error with clear

Parameters:
- OP_W, 3, instruction/op-code width.
- LEN_W, 6, data length and chunk counter width.
- NUM_CH, 2, number of processing units (1..16).
- TO_W, 8, watchdog counter width.
- TIMEOUT, 200, cycles allowed in any wait state before error; 0 disables the watchdog.
- CH_W (localparam), max(1, clog2(NUM_CH)), channel select width.

Ports:
- ctrl_clk  in  1  clock, all logic on rising edge
- ctrl_reset  in  1  synchronous active-high reset
- ctrl_instruction  in  OP_W  op-code for the processing unit
- ctrl_channel  in  CH_W  target processing unit index
- ctrl_valid_inst  in  1  instruction valid
- ctrl_valid_data  in  1  input data valid
- ctrl_data_in_size  in  LEN_W  block length
- ctrl_ready  out  1  high only in IDLE; request accepted when ready & valid_inst & valid_data
- ctrl_done  out  1  one-cycle pulse on normal completion
- ctrl_error  out  1  latched error flag
- ctrl_err_code  out  2  01 timeout, 10 bad channel, 00 none
- ctrl_err_clr  in  1  clears error and returns to IDLE
- ctrl_data_contition  out  3  data location: 000 none, 100 input, 010 memory, 001 register
- ctrl_chunk_cnt  out  LEN_W  processing passes completed in current request
- mc_done  in  1  memory controller transfer complete
- mc_data_done  in  1  memory controller: no data left
- mc_data_length  out  LEN_W  latched block length
- procc_instruction  out  OP_W  latched op-code
- procc_start  out  NUM_CH  one-hot start, held high during PROC on the selected channel
- procc_done  in  NUM_CH  per-unit completion

Behaviour:
- All outputs are registered.
- Reset (synchronous, priority over everything) clears every output to 0 and sets state IDLE, chunk counter 0, watchdog 0, latched channel 0.
- States: IDLE, STORE, TRANS, PROC, ERROR.
- IDLE: ctrl_ready=1.
  - On accept with ctrl_channel < NUM_CH: latch mc_data_length=size, procc_instruction=instruction, channel; set chunk_cnt=0, contition=100; go to STORE at the next edge.
  - On accept with ctrl_channel >= NUM_CH: go to ERROR with err_code=10; no latching besides the code.
- STORE: on mc_done → contition=010, go to TRANS.
- TRANS: on mc_done → contition=001, procc_start[ch]=1, go to PROC.
- PROC: only procc_done[ch] is observed; other bits are ignored.
  - procc_done[ch] & mc_data_done → contition=000, procc_start=0, chunk_cnt+1, ctrl_done=1 for one cycle, go to IDLE.
  - procc_done[ch] & !mc_data_done → contition=010, procc_start=0, chunk_cnt+1, go to TRANS.
  - chunk_cnt wraps modulo 2^LEN_W.
- Watchdog:
  - Cleared on every state change.
  - Increments each cycle spent in STORE/TRANS/PROC without an exit condition.
  - When the counter equals TIMEOUT (TIMEOUT>0) and no exit condition is present, go to ERROR with err_code=01.
  - An exit condition in the same cycle wins over the timeout.
  - The counter saturates and never wraps.
- ERROR: ctrl_error=1, contition=000, procc_start=0, ctrl_ready=0.
  - Inputs other than ctrl_err_clr are ignored.
  - ctrl_err_clr → IDLE with error=0, err_code=0, chunk_cnt kept until the next accept.
- mc_done outside STORE/TRANS is ignored; procc_done outside PROC is ignored.
- Reset mid-operation: drops procc_start and contition in the same edge; no done pulse.
- ctrl_done is never asserted on an error path.

Test Plan:
- Single chunk, ch=0, size=12, op=3'b101: accept; mc_done in STORE, mc_done in TRANS; procc_done[0]=1 and mc_data_done=1 → contition sequence 100→010→001→000; procc_start=01 during PROC; ctrl_done pulse 1 cycle; chunk_cnt=1; mc_data_length=12.
- Three chunks on ch=1: procc_done[1] twice with mc_data_done=0, third time with mc_data_done=1 → TRANS re-entered twice; procc_start=10; chunk_cnt=3; procc_done[0] pulses during PROC have no effect.
- Timeout, TIMEOUT=5: hold mc_done=0 in STORE → ERROR exactly 5 cycles after STORE entry; err_code=01; contition=000. Then err_clr → IDLE, ready=1.
- Bad channel with NUM_CH=3: ctrl_channel=3 → ERROR, err_code=10, procc_start=000, no STORE.
- Reset mid-PROC: ctrl_reset asserted during PROC → next edge: all outputs 0, IDLE; a subsequent request completes normally.
- Simultaneous exit and timeout: mc_done arrives on the cycle the watchdog equals TIMEOUT → TRANS taken, no error.
